// File: rtl/decode_queue_if.sv
// Bundle between an instruction fetch source, the decode queue and its consumer.
// Handshake: a transfer happens on a rising clock edge where valid and ready are both 1;
// a source holds valid and its payload stable until accepted, and ready never depends on valid.
interface decode_queue_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  // upstream side
  logic          i_valid;
  logic          o_ready;
  logic [31:0]   i_instr;
  logic [31:0]   i_pc;
  logic          i_flush;

  // downstream side (head entry)
  logic          o_valid;
  logic          i_ready;
  logic [31:0]   o_pc;
  logic [31:0]   o_imm;
  logic [11:0]   o_csr_addr;
  logic [4:0]    o_rs1;
  logic [4:0]    o_rs2;
  logic [4:0]    o_rd;
  logic [1:0]    o_alu_a_mux_sel;
  logic [1:0]    o_alu_b_mux_sel;
  logic [3:0]    o_alu_op;
  logic          o_csr_enable;
  logic          o_illegal;
  logic [CW-1:0] o_count;

  modport slave (
    input  i_valid, i_instr, i_pc, i_flush, i_ready,
    output o_ready, o_valid, o_pc, o_imm, o_csr_addr, o_rs1, o_rs2, o_rd,
           o_alu_a_mux_sel, o_alu_b_mux_sel, o_alu_op, o_csr_enable, o_illegal, o_count
  );

  modport master (
    output i_valid, i_instr, i_pc, i_flush, i_ready,
    input  o_ready, o_valid, o_pc, o_imm, o_csr_addr, o_rs1, o_rs2, o_rd,
           o_alu_a_mux_sel, o_alu_b_mux_sel, o_alu_op, o_csr_enable, o_illegal, o_count
  );
endinterface

// File: rtl/decode_queue.sv
// RV32I decode stage feeding a small FIFO of decoded bundles; decode happens on push,
// and the head bundle is held in a register so it stays put while the queue is empty.
module decode_queue #(
  parameter int DEPTH  = 2,
  parameter int CSR_EN = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  decode_queue_if.slave q
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;
  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [11:0] csr_addr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [3:0]  alu_op;
    logic        csr_enable;
    logic        illegal;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head_q;
  entry_t        dec;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_next;
  logic          push;
  logic          pop;
  logic          clear;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm_z;

  assign instr  = q.i_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_z  = {27'b0, instr[19:15]};

  // Opcode compare covers all 7 bits, so a compressed encoding (instr[1:0] != 11) falls to default.
  always_comb begin
    dec          = '0;
    dec.pc       = q.i_pc;
    dec.rd       = instr[11:7];
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.csr_addr = instr[31:20];
    dec.a_sel    = A_RS1;
    dec.b_sel    = B_RS2;
    dec.alu_op   = ALU_ADD;
    case (opcode)
      OPC_LUI: begin
        dec.imm   = imm_u;
        dec.a_sel = A_ZERO;
        dec.b_sel = B_IMM;
      end
      OPC_AUIPC: begin
        dec.imm   = imm_u;
        dec.a_sel = A_PC;
        dec.b_sel = B_IMM;
      end
      OPC_JAL: begin
        dec.imm   = imm_j;
        dec.a_sel = A_PC;
        dec.b_sel = B_FOUR;
      end
      OPC_JALR: begin
        dec.imm   = imm_i;
        dec.a_sel = A_PC;
        dec.b_sel = B_FOUR;
      end
      OPC_BRANCH: begin
        dec.imm    = imm_b;
        dec.alu_op = ALU_SUB;
      end
      OPC_LOAD, OPC_MISC_MEM: begin
        dec.imm   = imm_i;
        dec.b_sel = B_IMM;
      end
      OPC_STORE: begin
        dec.imm   = imm_s;
        dec.b_sel = B_IMM;
      end
      OPC_OP_IMM: begin
        dec.imm    = imm_i;
        dec.b_sel  = B_IMM;
        dec.alu_op = {(funct3 == 3'b101) & instr[30], funct3};
      end
      OPC_OP: begin
        dec.alu_op = {instr[30], funct3};
      end
      OPC_SYSTEM: begin
        dec.imm   = funct3[2] ? imm_z : imm_i;
        dec.b_sel = B_IMM;
        if (funct3 != 3'b000) begin
          if (CSR_EN != 0) dec.csr_enable = 1'b1;
          else             dec.illegal    = 1'b1;
        end
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  assign clear   = !i_reset || q.i_flush;
  assign push    = q.i_valid && q.o_ready;
  assign pop     = (count != '0) && q.i_ready;
  assign rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (clear) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count  <= count_next;
      rd_ptr <= rd_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!clear && push) mem[wr_ptr] <= dec;
  end

  // The only time the next head is the bundle being written is when it becomes the sole entry.
  always_ff @(posedge i_clk) begin
    if (!clear && count_next != '0) begin
      if (push && count_next == CW'(1)) head_q <= dec;
      else                              head_q <= mem[rd_next];
    end
  end

  assign q.o_ready         = count < CW'(DEPTH);
  assign q.o_valid         = count != '0;
  assign q.o_count         = count;
  assign q.o_pc            = head_q.pc;
  assign q.o_imm           = head_q.imm;
  assign q.o_csr_addr      = head_q.csr_addr;
  assign q.o_rs1           = head_q.rs1;
  assign q.o_rs2           = head_q.rs2;
  assign q.o_rd            = head_q.rd;
  assign q.o_alu_a_mux_sel = head_q.a_sel;
  assign q.o_alu_b_mux_sel = head_q.b_sel;
  assign q.o_alu_op        = head_q.alu_op;
  assign q.o_csr_enable    = head_q.csr_enable;
  assign q.o_illegal       = head_q.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios plus random traffic against a queue-based model,
// with a CSR_EN=1 and a CSR_EN=0 instance sharing the same stimulus.
module tb_decode_queue;
  localparam int DEPTH = 2;

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  decode_queue_if #(.DEPTH(DEPTH)) bus_a ();
  decode_queue_if #(.DEPTH(DEPTH)) bus_b ();

  assign bus_b.i_valid = bus_a.i_valid;
  assign bus_b.i_instr = bus_a.i_instr;
  assign bus_b.i_pc    = bus_a.i_pc;
  assign bus_b.i_flush = bus_a.i_flush;
  assign bus_b.i_ready = bus_a.i_ready;

  decode_queue #(.DEPTH(DEPTH), .CSR_EN(1)) dut_a (.i_clk(i_clk), .i_reset(i_reset), .q(bus_a));
  decode_queue #(.DEPTH(DEPTH), .CSR_EN(0)) dut_b (.i_clk(i_clk), .i_reset(i_reset), .q(bus_b));

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];  // {pc, instr} in push order
  logic [31:0] pc_ctr = 32'h100;

  typedef struct {
    logic [31:0] imm;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [3:0]  alu_op;
    logic        csr_en;
    logic        ill;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode built from the RV32I field layouts with plain arithmetic.
  function automatic exp_t model_decode(input logic [31:0] ins, input bit csr_on);
    exp_t e;
    logic [31:0] iv, sv, bv, uv, jv;
    iv = 32'($signed(ins) >>> 20);
    sv = 32'(($signed(ins) >>> 25) * 32) + 32'(ins[11:7]);
    bv = 32'(ins[31]) * 32'hFFFF_F000 + 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
    uv = ins & 32'hFFFF_F000;
    jv = 32'(ins[31]) * 32'hFFF0_0000 + 32'(ins[19:12]) * 4096 + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2;
    e = '{imm: 32'd0, a_sel: 2'd0, b_sel: 2'd0, alu_op: 4'd0, csr_en: 1'b0, ill: 1'b0};
    case (ins[6:0])
      7'h37: begin e.imm = uv; e.a_sel = 2; e.b_sel = 1; end
      7'h17: begin e.imm = uv; e.a_sel = 1; e.b_sel = 1; end
      7'h6F: begin e.imm = jv; e.a_sel = 1; e.b_sel = 2; end
      7'h67: begin e.imm = iv; e.a_sel = 1; e.b_sel = 2; end
      7'h63: begin e.imm = bv; e.alu_op = 4'd8; end
      7'h03, 7'h0F: begin e.imm = iv; e.b_sel = 1; end
      7'h23: begin e.imm = sv; e.b_sel = 1; end
      7'h13: begin
        e.imm = iv; e.b_sel = 1;
        e.alu_op = (ins[14:12] == 3'd5 && ins[30]) ? 4'd8 + 4'(ins[14:12]) : 4'(ins[14:12]);
      end
      7'h33: e.alu_op = ins[30] ? 4'd8 + 4'(ins[14:12]) : 4'(ins[14:12]);
      7'h73: begin
        e.imm = ins[14] ? 32'(ins[19:15]) : iv;
        e.b_sel = 1;
        if (ins[14:12] != 3'd0) begin
          e.csr_en = csr_on;
          e.ill = !csr_on;
        end
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check_head(input string t, input logic [63:0] ent, input bit csr_on,
                            input logic [31:0] pc, imm, input logic [11:0] csr,
                            input logic [4:0] rs1, rs2, rd, input logic [1:0] a, b,
                            input logic [3:0] op, input logic ce, il);
    exp_t e;
    e = model_decode(ent[31:0], csr_on);
    check({t, "_pc"}, pc, ent[63:32]);
    check({t, "_imm"}, imm, e.imm);
    check({t, "_csr_addr"}, 32'(csr), 32'(ent[31:20]));
    check({t, "_rs1"}, 32'(rs1), 32'(ent[19:15]));
    check({t, "_rs2"}, 32'(rs2), 32'(ent[24:20]));
    check({t, "_rd"}, 32'(rd), 32'(ent[11:7]));
    check({t, "_a_sel"}, 32'(a), 32'(e.a_sel));
    check({t, "_b_sel"}, 32'(b), 32'(e.b_sel));
    check({t, "_alu_op"}, 32'(op), 32'(e.alu_op));
    check({t, "_csr_en"}, 32'(ce), 32'(e.csr_en));
    check({t, "_illegal"}, 32'(il), 32'(e.ill));
  endtask

  task automatic check_state();
    int n;
    n = exp_q.size();
    check("count_a", 32'(bus_a.o_count), n);
    check("count_b", 32'(bus_b.o_count), n);
    check("valid", 32'(bus_a.o_valid), 32'(n != 0));
    check("ready", 32'(bus_a.o_ready), 32'(n < DEPTH));
    if (n > 0) begin
      check_head("a", exp_q[0], 1'b1, bus_a.o_pc, bus_a.o_imm, bus_a.o_csr_addr, bus_a.o_rs1,
                 bus_a.o_rs2, bus_a.o_rd, bus_a.o_alu_a_mux_sel, bus_a.o_alu_b_mux_sel,
                 bus_a.o_alu_op, bus_a.o_csr_enable, bus_a.o_illegal);
      check_head("b", exp_q[0], 1'b0, bus_b.o_pc, bus_b.o_imm, bus_b.o_csr_addr, bus_b.o_rs1,
                 bus_b.o_rs2, bus_b.o_rd, bus_b.o_alu_a_mux_sel, bus_b.o_alu_b_mux_sel,
                 bus_b.o_alu_op, bus_b.o_csr_enable, bus_b.o_illegal);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, update the model, check.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit fl, input bit rdy, input bit rst_n);
    bit m_push, m_pop;
    bus_a.i_valid = v;
    bus_a.i_instr = ins;
    bus_a.i_pc    = pc;
    bus_a.i_flush = fl;
    bus_a.i_ready = rdy;
    i_reset       = rst_n;
    m_push = v && (exp_q.size() < DEPTH);
    m_pop  = rdy && (exp_q.size() != 0);
    @(posedge i_clk);
    if (!rst_n || fl) begin
      exp_q.delete();
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({pc, ins});
    end
    @(negedge i_clk);
    check_state();
  endtask

  task automatic push_one(input logic [31:0] ins, input bit rdy);
    step(1'b1, ins, pc_ctr, 1'b0, rdy, 1'b1);
    pc_ctr = pc_ctr + 4;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [0:10];
    logic [31:0] r;
    int          sel;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    r   = $urandom();
    sel = $urandom_range(0, 13);
    if (sel <= 10) r[6:0] = ops[sel];
    if (sel == 10 && $urandom_range(0, 3) == 0) r[14:12] = 3'b000;
    return r;
  endfunction

  initial begin
    i_reset       = 1'b0;
    bus_a.i_valid = 1'b0;
    bus_a.i_instr = '0;
    bus_a.i_pc    = '0;
    bus_a.i_flush = 1'b0;
    bus_a.i_ready = 1'b0;
    @(negedge i_clk);

    // reset, with a push and flush offered that must be ignored
    step(1'b1, 32'h00500613, 32'h40, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // addi x12, x0, 5 then lui x1 then an all-ones word, consumer stalled
    push_one(32'h00500613, 1'b0);
    check("addi_valid", 32'(bus_a.o_valid), 32'd1);
    check("addi_rd", 32'(bus_a.o_rd), 32'd12);
    check("addi_rs1", 32'(bus_a.o_rs1), 32'd0);
    check("addi_imm", bus_a.o_imm, 32'd5);
    check("addi_pc", bus_a.o_pc, 32'h100);
    check("addi_illegal", 32'(bus_a.o_illegal), 32'd0);
    push_one(32'h123450B7, 1'b0);
    check("full_count", 32'(bus_a.o_count), 32'd2);
    check("full_ready", 32'(bus_a.o_ready), 32'd0);
    step(1'b1, 32'hFFFFFFFF, pc_ctr, 1'b0, 1'b0, 1'b1);
    check("held_count", 32'(bus_a.o_count), 32'd2);
    step(1'b1, 32'hFFFFFFFF, pc_ctr, 1'b0, 1'b1, 1'b1);
    check("lui_rd", 32'(bus_a.o_rd), 32'd1);
    check("lui_imm", bus_a.o_imm, 32'h12345000);
    check("lui_csr_en", 32'(bus_a.o_csr_enable), 32'd0);
    push_one(32'hFFFFFFFF, 1'b1);
    check("ones_illegal", 32'(bus_a.o_illegal), 32'd1);
    check("ones_csr_en", 32'(bus_a.o_csr_enable), 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

    // csrrw x5, mstatus, x6 on both CSR_EN settings
    push_one(32'h300312F3, 1'b0);
    check("csr_en_on", 32'(bus_a.o_csr_enable), 32'd1);
    check("csr_addr", 32'(bus_a.o_csr_addr), 32'h300);
    check("csr_legal_on", 32'(bus_a.o_illegal), 32'd0);
    check("csr_illegal_off", 32'(bus_b.o_illegal), 32'd1);
    check("csr_en_off", 32'(bus_b.o_csr_enable), 32'd0);

    // flush, then reset, each with a push offered in the same cycle
    push_one(32'h00C58593, 1'b0);
    step(1'b1, 32'h00100093, pc_ctr, 1'b1, 1'b0, 1'b1);
    check("flush_count", 32'(bus_a.o_count), 32'd0);
    check("flush_valid", 32'(bus_a.o_valid), 32'd0);
    push_one(32'h00208133, 1'b0);
    push_one(32'hFE000EE3, 1'b0);
    step(1'b1, 32'h00100093, pc_ctr, 1'b0, 1'b1, 1'b0);
    check("rst_count", 32'(bus_a.o_count), 32'd0);
    check("rst_valid", 32'(bus_a.o_valid), 32'd0);

    // full queue streaming with valid and ready held high
    push_one(rand_instr(), 1'b0);
    push_one(rand_instr(), 1'b0);
    for (int i = 0; i < 8; i++) push_one(rand_instr(), 1'b1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      bit v, rdy, fl, rst_n;
      v     = $urandom_range(0, 3) != 0;
      rdy   = $urandom_range(0, 2) != 0;
      fl    = $urandom_range(0, 39) == 0;
      rst_n = $urandom_range(0, 79) != 0;
      step(v, rand_instr(), pc_ctr, fl, rdy, rst_n);
      pc_ctr = pc_ctr + 4;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
